// File: rtl/systolic_skew_feeder.sv
// Operand buffer and diagonal-skew feeder for a K x K systolic array.
// Loads A column-by-column and B row-by-row, then streams 2K-1 skewed beats.
module systolic_skew_feeder #(
  parameter int N = 32,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K*N-1:0] a_col,
  input  logic [K*N-1:0] b_row,
  input  logic           start,
  output logic [K*N-1:0] a_out,
  output logic [K*N-1:0] b_out,
  output logic           out_valid,
  output logic           done
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int TW = $clog2(2 * K);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [TW-1:0] T_END  = TW'(2 * K - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [KW-1:0]   k_r;
  logic [TW-1:0]   t_r;
  logic [N-1:0]    a_buf_r [K][K];
  logic [N-1:0]    b_buf_r [K][K];
  logic [K*N-1:0]  a_beat_s;
  logic [K*N-1:0]  b_beat_s;
  logic            load_s;
  logic            beat_s;
  logic            finish_s;

  // Next-state and per-cycle action decode.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    beat_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          load_s  = 1'b1;
          state_s = (k_r == K_LAST) ? FULL : IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      FULL: begin
        if (start) begin
          beat_s  = 1'b1;
          state_s = STREAM;
        end else begin
          state_s = FULL;
        end
      end
      STREAM: begin
        if (t_r == T_END) begin
          finish_s = 1'b1;
          state_s  = DONE;
        end else begin
          beat_s  = 1'b1;
          state_s = STREAM;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Beat t selects element c = t - lane on each lane; at most one c matches per lane.
  always_comb begin
    a_beat_s = {(K*N){1'b0}};
    b_beat_s = {(K*N){1'b0}};
    for (int i = 0; i < K; i++) begin
      for (int c = 0; c < K; c++) begin
        a_beat_s[i*N +: N] = a_beat_s[i*N +: N] |
                             ((t_r == TW'(i + c)) ? a_buf_r[i][c] : {N{1'b0}});
        b_beat_s[i*N +: N] = b_beat_s[i*N +: N] |
                             ((t_r == TW'(i + c)) ? b_buf_r[c][i] : {N{1'b0}});
      end
    end
  end

  // Operand buffers, beat counter k and step counter t.
  always_ff @(posedge clk) begin
    if (!clr) begin
      k_r <= {KW{1'b0}};
      t_r <= {TW{1'b0}};
      for (int i = 0; i < K; i++) begin
        for (int c = 0; c < K; c++) begin
          a_buf_r[i][c] <= {N{1'b0}};
          b_buf_r[i][c] <= {N{1'b0}};
        end
      end
    end else begin
      if (load_s) begin
        for (int c = 0; c < K; c++) begin
          if (k_r == KW'(c)) begin
            for (int i = 0; i < K; i++) begin
              a_buf_r[i][c] <= a_col[i*N +: N];
              b_buf_r[c][i] <= b_row[i*N +: N];
            end
          end
        end
        k_r <= (k_r == K_LAST) ? {KW{1'b0}} : k_r + KW'(1);
      end
      if (beat_s) begin
        t_r <= t_r + TW'(1);
      end else if (finish_s) begin
        t_r <= {TW{1'b0}};
      end
    end
  end

  // Registered outputs; in_ready tracks the state being entered.
  always_ff @(posedge clk) begin
    if (!clr) begin
      a_out     <= {(K*N){1'b0}};
      b_out     <= {(K*N){1'b0}};
      out_valid <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      a_out     <= beat_s ? a_beat_s : {(K*N){1'b0}};
      b_out     <= beat_s ? b_beat_s : {(K*N){1'b0}};
      out_valid <= beat_s;
      done      <= finish_s;
      in_ready  <= (state_s == IDLE);
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed table for the K=4 example, corner sequences,
// randomized matrices checked against the skew formula, and a K=1 instance.
module tb_systolic_skew_feeder;

  logic         clk;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a_col;
  logic [127:0] b_row;
  logic         start;
  logic [127:0] a_out;
  logic [127:0] b_out;
  logic         out_valid;
  logic         done;

  logic         in_valid1;
  logic         in_ready1;
  logic [31:0]  a1_col;
  logic [31:0]  b1_row;
  logic         start1;
  logic [31:0]  a1_out;
  logic [31:0]  b1_out;
  logic         out_valid1;
  logic         done1;

  int checks;
  int errors;

  logic [31:0] ma [4][4];
  logic [31:0] mb [4][4];

  typedef struct {
    logic         ld;
    logic [127:0] a_col;
    logic [127:0] b_row;
    logic [127:0] exp_a;
    logic [127:0] exp_b;
  } vec_t;
  vec_t tbl [7];

  systolic_skew_feeder #(.N(32), .K(4)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .start(start),
    .a_out(a_out), .b_out(b_out), .out_valid(out_valid), .done(done)
  );

  systolic_skew_feeder #(.N(32), .K(1)) dut1 (
    .clk(clk), .clr(clr), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_col(a1_col), .b_row(b1_row), .start(start1),
    .a_out(a1_out), .b_out(b1_out), .out_valid(out_valid1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] p4(input int l0, input int l1, input int l2, input int l3);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  // Expected beat t from the skew rule: lane i shows A[i][t-i], lane j shows B[t-j][j].
  function automatic logic [127:0] exp_a(input int t);
    logic [127:0] r;
    r = 128'd0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i < 4) r[i*32 +: 32] = ma[i][t-i];
    return r;
  endfunction

  function automatic logic [127:0] exp_b(input int t);
    logic [127:0] r;
    r = 128'd0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j < 4) r[j*32 +: 32] = mb[t-j][j];
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 32'd0;
        mb[i][j] = 32'd0;
      end
  endtask

  task automatic rand_model();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = $urandom;
        mb[i][j] = $urandom;
      end
  endtask

  task automatic load_beat(input int k);
    for (int i = 0; i < 4; i++) begin
      a_col[i*32 +: 32] = ma[i][k];
      b_row[i*32 +: 32] = mb[k][i];
    end
    in_valid = 1'b1;
    chk($sformatf("in_ready_load%0d", k), in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_all(input int max_gap);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        chk("in_ready_gap", in_ready, 1'b1);
        @(negedge clk);
      end
      load_beat(k);
    end
    chk("in_ready_full", in_ready, 1'b0);
  endtask

  task automatic run_stream(input string nm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 7; t++) begin
      chk($sformatf("%s_valid_t%0d", nm, t), out_valid, 1'b1);
      chk($sformatf("%s_a_t%0d", nm, t), a_out, exp_a(t));
      chk($sformatf("%s_b_t%0d", nm, t), b_out, exp_b(t));
      chk($sformatf("%s_done_t%0d", nm, t), done, 1'b0);
      @(negedge clk);
    end
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_valid_end"}, out_valid, 1'b0);
    chk({nm, "_a_end"}, a_out, 128'd0);
    chk({nm, "_b_end"}, b_out, 128'd0);
    chk({nm, "_ready_done"}, in_ready, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_done_clear"}, done, 1'b0);
    chk({nm, "_ready_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b0;
    in_valid = 1'b0;
    start = 1'b0;
    a_col = 128'd0;
    b_row = 128'd0;
    in_valid1 = 1'b0;
    start1 = 1'b0;
    a1_col = 32'd0;
    b1_row = 32'd0;
    clear_model();

    for (int k = 0; k < 7; k++) begin
      tbl[k].ld    = (k < 4);
      tbl[k].a_col = (k < 4) ? p4(k, 10 + k, 20 + k, 30 + k) : 128'd0;
      tbl[k].b_row = (k < 4) ? p4(100 * k, 100 * k + 1, 100 * k + 2, 100 * k + 3) : 128'd0;
    end
    tbl[0].exp_a = p4(0, 0, 0, 0);    tbl[0].exp_b = p4(0, 0, 0, 0);
    tbl[1].exp_a = p4(1, 10, 0, 0);   tbl[1].exp_b = p4(100, 1, 0, 0);
    tbl[2].exp_a = p4(2, 11, 20, 0);  tbl[2].exp_b = p4(200, 101, 2, 0);
    tbl[3].exp_a = p4(3, 12, 21, 30); tbl[3].exp_b = p4(300, 201, 102, 3);
    tbl[4].exp_a = p4(0, 13, 22, 31); tbl[4].exp_b = p4(0, 301, 202, 103);
    tbl[5].exp_a = p4(0, 0, 23, 32);  tbl[5].exp_b = p4(0, 0, 302, 203);
    tbl[6].exp_a = p4(0, 0, 0, 33);   tbl[6].exp_b = p4(0, 0, 0, 303);

    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_a", a_out, 128'd0);
    chk("rst_b", b_out, 128'd0);
    chk("rst1_ready", in_ready1, 1'b1);
    chk("rst1_valid", out_valid1, 1'b0);

    // K=1 instance: single beat then done.
    a1_col = 32'd5;
    b1_row = 32'd2;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("k1_ready_full", in_ready1, 1'b0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("k1_valid", out_valid1, 1'b1);
    chk("k1_a", a1_out, 32'd5);
    chk("k1_b", b1_out, 32'd2);
    chk("k1_done_early", done1, 1'b0);
    @(negedge clk);
    chk("k1_valid_end", out_valid1, 1'b0);
    chk("k1_done", done1, 1'b1);
    chk("k1_a_end", a1_out, 32'd0);
    @(negedge clk);
    chk("k1_done_clear", done1, 1'b0);
    chk("k1_ready_idle", in_ready1, 1'b1);

    // Directed table: the worked 4x4 example.
    for (int r = 0; r < 7; r++) begin
      if (tbl[r].ld) begin
        a_col = tbl[r].a_col;
        b_row = tbl[r].b_row;
        in_valid = 1'b1;
        chk($sformatf("tbl_ready%0d", r), in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    chk("tbl_full", in_ready, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 7; r++) begin
      chk($sformatf("tbl_valid%0d", r), out_valid, 1'b1);
      chk($sformatf("tbl_a%0d", r), a_out, tbl[r].exp_a);
      chk($sformatf("tbl_b%0d", r), b_out, tbl[r].exp_b);
      @(negedge clk);
    end
    chk("tbl_done", done, 1'b1);
    chk("tbl_valid_end", out_valid, 1'b0);
    @(negedge clk);
    chk("tbl_done_clear", done, 1'b0);

    // in_valid held high through FULL and STREAM must not disturb the buffers.
    rand_model();
    load_all(0);
    a_col = {$urandom, $urandom, $urandom, $urandom};
    b_row = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_ready", in_ready, 1'b0);
    chk("hold_valid", out_valid, 1'b0);
    run_stream("hold");
    rand_model();
    load_all(1);
    run_stream("reload");

    // start during a partial load is ignored and loading resumes at k=2.
    rand_model();
    load_beat(0);
    load_beat(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("early_start_valid", out_valid, 1'b0);
    chk("early_start_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("early_start_valid2", out_valid, 1'b0);
    load_beat(2);
    load_beat(3);
    chk("early_full", in_ready, 1'b0);
    run_stream("resume");

    // Reset in the middle of a stream.
    rand_model();
    load_all(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      chk($sformatf("mid_a_t%0d", t), a_out, exp_a(t));
      if (t < 3) @(negedge clk);
    end
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    clear_model();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_a", a_out, 128'd0);
    chk("mid_rst_b", b_out, 128'd0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("noreload_valid", out_valid, 1'b0);
      chk("noreload_ready", in_ready, 1'b1);
      @(negedge clk);
    end

    // Randomized matrices with load gaps and FULL dwell.
    for (int it = 0; it < 8; it++) begin
      rand_model();
      load_all(2);
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(0, 1));
        a_col = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("rand_dwell_valid", out_valid, 1'b0);
        chk("rand_dwell_ready", in_ready, 1'b0);
      end
      run_stream($sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
